pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Drives hold/flush to the pc register and the if_id, id_ex and ex_mem pipeline registers, plus redirect to the pc.
- Resolves load-use hazards, taken jumps/branches from EX, multi-cycle divide in EX and data-bus wait states in MEM, in one fixed priority.

---
 rtl/pipe_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard sequencer for the 5-stage core; hold/flush/redirect outputs are combinational
// from state and inputs, only state is registered. Build with PIPE_PERF_EN for stall/flush counters.
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RAW    = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAW-1:0]    id_rs1,
  input  logic [RAW-1:0]    id_rs2,
  input  logic              id_rs1_re,
  input  logic              id_rs2_re,
  input  logic [RAW-1:0]    ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_jump_req,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              ex_div_start,
  input  logic              div_done,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_hold,
  output logic              id_ex_flush,
  output logic              ex_mem_hold,
  output logic              ex_mem_flush,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_addr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DIV_WAIT = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   done_pend_q, done_pend_d;
  logic   mem_wait, load_use;

  logic pc_h, if_id_h, if_id_f, id_ex_h, id_ex_f, ex_mem_h, ex_mem_f, jmp;
  logic run_rules, lu_ok;

  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = ex_is_load & (ex_rd != '0) &
                    ((id_rs1_re & (id_rs1 == ex_rd)) | (id_rs2_re & (id_rs2 == ex_rd)));

  // Successor state under the RUN priority order; a taken jump keeps us in RUN.
  function automatic state_t run_next(input logic mw, input logic ds,
                                      input logic jr, input logic lu);
    if (mw)      return MEM_WAIT;
    else if (ds) return DIV_WAIT;
    else if (jr) return RUN;
    else if (lu) return LU_STALL;
    else         return RUN;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_pend_d = done_pend_q;
    unique case (state_q)
      RUN:      state_d = run_next(mem_wait, ex_div_start, ex_jump_req, load_use);
      LU_STALL: state_d = run_next(mem_wait, ex_div_start, ex_jump_req, 1'b0);
      MEM_WAIT: begin
        if (mem_ready)
          state_d = run_next(mem_wait, ex_div_start, ex_jump_req, load_use);
      end
      DIV_WAIT: begin
        // A completion seen while MEM is stuck is remembered until the bus releases.
        if (mem_wait) begin
          done_pend_d = done_pend_q | div_done;
        end else if (div_done | done_pend_q) begin
          state_d     = RUN;
          done_pend_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_h      = 1'b0;
    if_id_h   = 1'b0;
    if_id_f   = 1'b0;
    id_ex_h   = 1'b0;
    id_ex_f   = 1'b0;
    ex_mem_h  = 1'b0;
    ex_mem_f  = 1'b0;
    jmp       = 1'b0;
    run_rules = 1'b0;
    lu_ok     = 1'b1;
    unique case (state_q)
      RUN:      run_rules = 1'b1;
      LU_STALL: begin
        run_rules = 1'b1;
        lu_ok     = 1'b0;
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_h     = 1'b1;
          if_id_h  = 1'b1;
          id_ex_h  = 1'b1;
          ex_mem_h = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      DIV_WAIT: begin
        if (mem_wait) begin
          pc_h     = 1'b1;
          if_id_h  = 1'b1;
          id_ex_h  = 1'b1;
          ex_mem_h = 1'b1;
        end else if (!(div_done | done_pend_q)) begin
          pc_h     = 1'b1;
          if_id_h  = 1'b1;
          id_ex_h  = 1'b1;
          ex_mem_f = 1'b1;
        end
      end
      default: run_rules = 1'b0;
    endcase

    if (run_rules) begin
      if (mem_wait) begin
        pc_h     = 1'b1;
        if_id_h  = 1'b1;
        id_ex_h  = 1'b1;
        ex_mem_h = 1'b1;
      end else if (ex_div_start) begin
        pc_h     = 1'b1;
        if_id_h  = 1'b1;
        id_ex_h  = 1'b1;
        ex_mem_f = 1'b1;
      end else if (ex_jump_req) begin
        jmp     = 1'b1;
        if_id_f = 1'b1;
        id_ex_f = 1'b1;
      end else if (lu_ok && load_use) begin
        pc_h    = 1'b1;
        if_id_h = 1'b1;
        id_ex_f = 1'b1;
      end
    end
  end

  // Reset forces everything quiet at once; flush wins over hold on the same register.
  assign pc_hold      = ~rst & pc_h;
  assign if_id_flush  = ~rst & if_id_f;
  assign if_id_hold   = ~rst & if_id_h & ~if_id_f;
  assign id_ex_flush  = ~rst & id_ex_f;
  assign id_ex_hold   = ~rst & id_ex_h & ~id_ex_f;
  assign ex_mem_flush = ~rst & ex_mem_f;
  assign ex_mem_hold  = ~rst & ex_mem_h & ~ex_mem_f;
  assign jump_en      = ~rst & jmp;
  assign jump_addr    = jump_en ? ex_jump_addr : '0;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (jump_en) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a flag-based reference model.
module tb_pipe_ctrl;
  localparam int ADDR_W = 32;
  localparam int RAW    = 5;
  localparam int CNT_W  = 32;

  localparam logic [7:0] E_NONE     = 8'b0000_0000;
  localparam logic [7:0] E_ALL_HOLD = 8'b1101_0100;
  localparam logic [7:0] E_DIV      = 8'b1101_0010;
  localparam logic [7:0] E_JUMP     = 8'b0010_1001;
  localparam logic [7:0] E_LU       = 8'b1100_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RAW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_re, id_rs2_re, ex_is_load, ex_jump_req, ex_div_start, div_done, mem_req, mem_ready;
  logic [ADDR_W-1:0] ex_jump_addr;
  logic pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, ex_mem_flush, jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] act_vec;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(ADDR_W), .RAW(RAW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr),
    .ex_div_start(ex_div_start), .div_done(div_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .ex_mem_flush(ex_mem_flush),
    .jump_en(jump_en), .jump_addr(jump_addr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign act_vec = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                    ex_mem_hold, ex_mem_flush, jump_en};

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        re1;
    logic        re2;
    logic [4:0]  rd;
    logic        ld;
    logic        jr;
    logic [31:0] ja;
    logic        ds;
    logic        dd;
    logic        mq;
    logic        mr;
  } stim_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: what the pipeline is waiting on, as plain flags.
  logic m_memblk = 1'b0, m_div = 1'b0, m_pend = 1'b0, m_luprev = 1'b0;
  logic n_memblk, n_div, n_pend, n_luprev;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;
  logic [7:0]  exp_vec;
  logic [31:0] exp_addr;

  function automatic logic [CNT_W-1:0] exp_sc();
`ifdef PIPE_PERF_EN
    return m_stall;
`else
    return '0;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] exp_fc();
`ifdef PIPE_PERF_EN
    return m_flush;
`else
    return '0;
`endif
  endfunction

  task automatic apply(input stim_t s);
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rs1_re = s.re1; id_rs2_re = s.re2;
    ex_rd = s.rd; ex_is_load = s.ld; ex_jump_req = s.jr; ex_jump_addr = s.ja;
    ex_div_start = s.ds; div_done = s.dd; mem_req = s.mq; mem_ready = s.mr;
  endtask

  task automatic eval_model();
    logic mw, lu;
    mw = mem_req && !mem_ready;
    lu = ex_is_load && (ex_rd != 0) &&
         ((id_rs1_re && id_rs1 == ex_rd) || (id_rs2_re && id_rs2 == ex_rd));
    exp_vec = E_NONE; exp_addr = '0;
    n_memblk = 1'b0; n_div = m_div; n_pend = m_pend; n_luprev = 1'b0;
    if (rst) begin
      n_div = 1'b0; n_pend = 1'b0;
    end else if (m_div) begin
      if (mw) begin
        exp_vec = E_ALL_HOLD; n_pend = m_pend || div_done;
      end else if (div_done || m_pend) begin
        n_div = 1'b0; n_pend = 1'b0;
      end else begin
        exp_vec = E_DIV;
      end
    end else if ((m_memblk && !mem_ready) || mw) begin
      exp_vec = E_ALL_HOLD; n_memblk = 1'b1;
    end else if (ex_div_start) begin
      exp_vec = E_DIV; n_div = 1'b1; n_pend = 1'b0;
    end else if (ex_jump_req) begin
      exp_vec = E_JUMP; exp_addr = ex_jump_addr;
    end else if (lu && !m_luprev) begin
      exp_vec = E_LU; n_luprev = 1'b1;
    end
  endtask

  task automatic model_clear();
    m_memblk = 1'b0; m_div = 1'b0; m_pend = 1'b0; m_luprev = 1'b0;
    m_stall = '0; m_flush = '0;
  endtask

  task automatic to_check();
    @(negedge clk);
    eval_model();
  endtask

  task automatic to_next();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      m_memblk = n_memblk; m_div = n_div; m_pend = n_pend; m_luprev = n_luprev;
      if (exp_vec[7]) m_stall = m_stall + 1'b1;
      if (exp_vec[0]) m_flush = m_flush + 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    logic [63:0] r;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      r = {$urandom(), $urandom()};
      s = r[54:0];
      s.mq = 1'b1; s.mr = 1'b0;
      apply(s);
      to_check();
      n_cmp++;
      if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {E_NONE, 32'h0, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
        n_fail++;
        $display("FAIL reset c%0d: got %b %h %0d %0d, expected all zero", c, act_vec, jump_addr, stall_cnt, flush_cnt);
      end
      to_next();
    end
    apply('0);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t s;
    for (int c = 0; c < 8; c++) begin
      s = '0;
      case (c)
        0, 1: begin s.ld = 1; s.rd = 5; s.rs1 = 5; s.re1 = 1; end
        3:    begin s.ld = 1; s.rd = 0; s.rs1 = 0; s.re1 = 1; end
        4:    begin s.ld = 1; s.rd = 7; s.rs2 = 7; s.re2 = 1; end
        6:    begin s.ld = 1; s.rd = 7; s.rs2 = 7; s.re2 = 0; end
        7:    begin s.ld = 0; s.rd = 9; s.rs1 = 9; s.re1 = 1; end
        default: s = '0;
      endcase
      apply(s);
      to_check();
      n_cmp++;
      if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {exp_vec, exp_addr, exp_sc(), exp_fc()}) begin
        n_fail++;
        $display("FAIL load_use c%0d: got %b %h %0d %0d, expected %b %h %0d %0d",
                 c, act_vec, jump_addr, stall_cnt, flush_cnt, exp_vec, exp_addr, exp_sc(), exp_fc());
      end
      to_next();
    end
  endtask

  task automatic test_jump_over_lu();
    stim_t s;
    for (int c = 0; c < 3; c++) begin
      s = '0;
      if (c < 2) begin s.ld = 1; s.rd = 5; s.rs1 = 5; s.re1 = 1; end
      if (c == 0) begin s.jr = 1; s.ja = 32'h0000_0100; end
      apply(s);
      to_check();
      n_cmp++;
      if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {exp_vec, exp_addr, exp_sc(), exp_fc()}) begin
        n_fail++;
        $display("FAIL jump_over_lu c%0d: got %b %h %0d %0d, expected %b %h %0d %0d",
                 c, act_vec, jump_addr, stall_cnt, flush_cnt, exp_vec, exp_addr, exp_sc(), exp_fc());
      end
      to_next();
    end
  endtask

  task automatic test_mem_wait();
    stim_t s;
    int held_jumps = 0;
    for (int c = 0; c < 6; c++) begin
      s = '0;
      if (c < 4) begin s.mq = 1; s.mr = (c == 3); s.jr = 1; s.ja = 32'h0000_0200; end
      apply(s);
      to_check();
      if (c < 3 && jump_en) held_jumps++;
      n_cmp++;
      if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {exp_vec, exp_addr, exp_sc(), exp_fc()}) begin
        n_fail++;
        $display("FAIL mem_wait c%0d: got %b %h %0d %0d, expected %b %h %0d %0d",
                 c, act_vec, jump_addr, stall_cnt, flush_cnt, exp_vec, exp_addr, exp_sc(), exp_fc());
      end
      to_next();
    end
    n_cmp++;
    if (held_jumps !== 0) begin
      n_fail++;
      $display("FAIL mem_wait_jump_held: got %0d jump cycles, expected 0", held_jumps);
    end
  endtask

  task automatic test_div();
    stim_t s;
    int div_cycles = 0;
    for (int c = 0; c < 36; c++) begin
      s = '0;
      s.ds = (c == 0);
      s.dd = (c == 33);
      if (c == 35) begin s.jr = 1; s.ja = 32'h0000_0300; end
      apply(s);
      to_check();
      if (act_vec == E_DIV) div_cycles++;
      n_cmp++;
      if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {exp_vec, exp_addr, exp_sc(), exp_fc()}) begin
        n_fail++;
        $display("FAIL div c%0d: got %b %h %0d %0d, expected %b %h %0d %0d",
                 c, act_vec, jump_addr, stall_cnt, flush_cnt, exp_vec, exp_addr, exp_sc(), exp_fc());
      end
      to_next();
    end
    n_cmp++;
    if (div_cycles !== 33) begin
      n_fail++;
      $display("FAIL div_length: got %0d hold cycles, expected 33", div_cycles);
    end
  endtask

  task automatic test_div_mem();
    stim_t s;
    for (int c = 0; c < 9; c++) begin
      s = '0;
      case (c)
        0: s.ds = 1;
        2: begin s.mq = 1; s.mr = 0; end
        4: begin s.mq = 1; s.mr = 0; s.dd = 1; end
        5: begin s.mq = 1; s.mr = 0; end
        6: begin s.mq = 1; s.mr = 1; end
        8: begin s.jr = 1; s.ja = 32'h0000_0400; end
        default: s = '0;
      endcase
      apply(s);
      to_check();
      n_cmp++;
      if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {exp_vec, exp_addr, exp_sc(), exp_fc()}) begin
        n_fail++;
        $display("FAIL div_mem c%0d: got %b %h %0d %0d, expected %b %h %0d %0d",
                 c, act_vec, jump_addr, stall_cnt, flush_cnt, exp_vec, exp_addr, exp_sc(), exp_fc());
      end
      to_next();
    end
  endtask

  task automatic test_reset_mid_div();
    stim_t s;
    for (int c = 0; c < 4; c++) begin
      s = '0;
      s.ds = (c == 0);
      apply(s);
      to_check();
      n_cmp++;
      if ({act_vec, jump_addr} !== {exp_vec, exp_addr}) begin
        n_fail++;
        $display("FAIL rst_div_pre c%0d: got %b %h, expected %b %h", c, act_vec, jump_addr, exp_vec, exp_addr);
      end
      to_next();
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {E_NONE, 32'h0, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL rst_div_async: got %b %h %0d %0d, expected all zero", act_vec, jump_addr, stall_cnt, flush_cnt);
    end
    eval_model();
    to_next();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s = '0;
      s.dd = (c == 0);
      if (c == 2) begin s.jr = 1; s.ja = 32'h0000_0500; end
      apply(s);
      to_check();
      n_cmp++;
      if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {exp_vec, exp_addr, exp_sc(), exp_fc()}) begin
        n_fail++;
        $display("FAIL rst_div_post c%0d: got %b %h %0d %0d, expected %b %h %0d %0d",
                 c, act_vec, jump_addr, stall_cnt, flush_cnt, exp_vec, exp_addr, exp_sc(), exp_fc());
      end
      to_next();
    end
  endtask

  task automatic test_perf();
    stim_t s;
    logic [CNT_W-1:0] want_s, want_f;
    apply('0);
    rst = 1'b1;
    to_check();
    to_next();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      s = '0;
      case (c)
        0:       begin s.ld = 1; s.rd = 3; s.rs1 = 3; s.re1 = 1; end
        2, 3, 4: begin s.mq = 1; s.mr = 0; end
        5:       begin s.mq = 1; s.mr = 1; end
        6:       begin s.jr = 1; s.ja = 32'h0000_0040; end
        7:       begin s.jr = 1; s.ja = 32'h0000_0080; end
        default: s = '0;
      endcase
      apply(s);
      to_check();
      to_next();
    end
`ifdef PIPE_PERF_EN
    want_s = 4; want_f = 2;
`else
    want_s = 0; want_f = 0;
`endif
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {want_s, want_f}) begin
      n_fail++;
      $display("FAIL perf: got stall %0d flush %0d, expected stall %0d flush %0d",
               stall_cnt, flush_cnt, want_s, want_f);
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int c = 0; c < 2000; c++) begin
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.re1 = ($urandom_range(0, 1) == 1);
      s.re2 = ($urandom_range(0, 1) == 1);
      s.ld  = ($urandom_range(0, 1) == 1);
      s.jr  = ($urandom_range(0, 4) == 0);
      s.ja  = $urandom();
      s.ds  = ($urandom_range(0, 11) == 0);
      s.dd  = ($urandom_range(0, 5) == 0);
      s.mq  = ($urandom_range(0, 2) == 0);
      s.mr  = ($urandom_range(0, 1) == 1);
      apply(s);
      to_check();
      n_cmp++;
      if ({act_vec, jump_addr, stall_cnt, flush_cnt} !== {exp_vec, exp_addr, exp_sc(), exp_fc()}) begin
        n_fail++;
        $display("FAIL random c%0d: got %b %h %0d %0d, expected %b %h %0d %0d",
                 c, act_vec, jump_addr, stall_cnt, flush_cnt, exp_vec, exp_addr, exp_sc(), exp_fc());
      end
      to_next();
    end
  endtask

  initial begin
    apply('0);
    test_reset();
    test_load_use();
    test_jump_over_lu();
    test_mem_wait();
    test_div();
    test_div_mem();
    test_reset_mid_div();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
